// File: rtl/building_measure_sched.sv
// Per-frame scheduler for the building stripe measurement: captures frame data on eop
// and time-shares one restoring divider between the distance and diameter quotients.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting for eop; start_q marks the capture cycle after eop
// S_DIST   | divider running CALI_SIZE*CALI_DISTANCE / (2*stripe_width)
// S_DIAM   | divider running span / stripe_width
// S_PUB    | load output registers, pulse result_valid
module building_measure_sched #(
   parameter int CALI_SIZE     = 70,
   parameter int CALI_DISTANCE = 30,
   parameter int IMAGE_W       = 640
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        eop,
   input  logic [10:0] stripe_width,
   input  logic [10:0] left_most_bound,
   input  logic [10:0] right_most_bound,
   input  logic [4:0]  left_slot,
   input  logic [4:0]  right_slot,
   input  logic [4:0]  center_slot,
   output logic        busy,
   output logic        result_valid,
   output logic [11:0] distance,
   output logic [11:0] diameter,
   output logic [10:0] target_center_x_pixel,
   output logic        formate,
   output logic        building_valid,
   output logic [7:0]  frame_drop_cnt
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_DIST = 2'd1;
   localparam logic [1:0] S_DIAM = 2'd2;
   localparam logic [1:0] S_PUB  = 2'd3;

   localparam logic [15:0] DIST_DVD  = 16'(CALI_SIZE * CALI_DISTANCE);
   localparam logic [10:0] BOUND_MAX = 11'(IMAGE_W - 1);

   logic [1:0]  state_q, state_d;
   logic        start_q, start_d;
   logic [10:0] sw_q, sw_d, lb_q, lb_d, rb_q, rb_d;
   logic [4:0]  ls_q, ls_d, rs_q, rs_d, cs_q, cs_d;
   logic [11:0] rem_q, rem_d, dsr_q, dsr_d, qdist_q, qdist_d;
   logic [15:0] dvd_q, dvd_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        valid_q, valid_d, form_q, form_d, bv_q, bv_d;
   logic [11:0] dist_q, dist_d, diam_q, diam_d;
   logic [10:0] tcx_q, tcx_d;
   logic [7:0]  drop_q, drop_d;

   logic        accept, run, last, qbit;
   logic [12:0] trial;
   logic [10:0] lb_c, rb_c, span, tcx_c;

   assign accept = eop && (state_q == S_IDLE) && !start_q;
   // The first quotient step happens on the edge that leaves the capture cycle.
   assign run    = (start_q && (sw_q != 11'd0)) || (state_q == S_DIST) || (state_q == S_DIAM);
   assign last   = (cnt_q == 4'd0);
   assign trial  = {rem_q, dvd_q[15]} - {1'b0, dsr_q};
   assign qbit   = ~trial[12];
   assign lb_c   = (lb_q > BOUND_MAX) ? BOUND_MAX : lb_q;
   assign rb_c   = (rb_q > BOUND_MAX) ? BOUND_MAX : rb_q;
   assign span   = (rb_c > lb_c) ? (rb_c - lb_c) : 11'd0;
   assign tcx_c  = (cs_q == 5'd0) ? 11'd0 : (11'(cs_q) * 11'd40 - 11'd20);

   always_comb begin
      state_d = state_q;
      start_d = start_q;
      sw_d    = sw_q;
      lb_d    = lb_q;
      rb_d    = rb_q;
      ls_d    = ls_q;
      rs_d    = rs_q;
      cs_d    = cs_q;
      rem_d   = rem_q;
      dvd_d   = dvd_q;
      dsr_d   = dsr_q;
      cnt_d   = cnt_q;
      qdist_d = qdist_q;
      valid_d = 1'b0;
      dist_d  = dist_q;
      diam_d  = diam_q;
      tcx_d   = tcx_q;
      form_d  = form_q;
      bv_d    = bv_q;
      drop_d  = drop_q;

      if (accept) begin
         start_d = 1'b1;
         sw_d    = stripe_width;
         lb_d    = left_most_bound;
         rb_d    = right_most_bound;
         ls_d    = left_slot;
         rs_d    = right_slot;
         cs_d    = center_slot;
         if (stripe_width != 11'd0) begin
            rem_d = 12'd0;
            dvd_d = DIST_DVD;
            dsr_d = {stripe_width, 1'b0};
            cnt_d = 4'd15;
         end
      end else if (eop && (drop_q != 8'hff)) begin
         drop_d = drop_q + 8'd1;
      end

      if (run) begin
         rem_d = qbit ? trial[11:0] : {rem_q[10:0], dvd_q[15]};
         dvd_d = {dvd_q[14:0], qbit};
         cnt_d = cnt_q - 4'd1;
      end

      case (state_q)
         S_IDLE: begin
            if (start_q) begin
               start_d = 1'b0;
               state_d = (sw_q == 11'd0) ? S_PUB : S_DIST;
            end
         end
         S_DIST: begin
            if (last) begin
               qdist_d = {dvd_q[10:0], qbit};
               rem_d   = 12'd0;
               dvd_d   = {5'd0, span};
               dsr_d   = {1'b0, sw_q};
               cnt_d   = 4'd15;
               state_d = S_DIAM;
            end
         end
         S_DIAM: begin
            if (last) state_d = S_PUB;
         end
         default: begin
            state_d = S_IDLE;
            valid_d = 1'b1;
            dist_d  = (sw_q == 11'd0) ? 12'd0 : qdist_q;
            diam_d  = (sw_q == 11'd0) ? 12'd0 : {dvd_q[10:0], 1'b0};
            tcx_d   = tcx_c;
            form_d  = (cs_q == 5'd8) || (cs_q == 5'd9);
            bv_d    = (sw_q != 11'd0) && !((ls_q <= 5'd1) && (rs_q >= 5'd15)) &&
                      !({1'b0, rs_q} <= ({1'b0, ls_q} + 6'd2));
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         start_q <= 1'b0;
         sw_q    <= '0;
         lb_q    <= '0;
         rb_q    <= '0;
         ls_q    <= '0;
         rs_q    <= '0;
         cs_q    <= '0;
         rem_q   <= '0;
         dvd_q   <= '0;
         dsr_q   <= '0;
         cnt_q   <= '0;
         qdist_q <= '0;
         valid_q <= 1'b0;
         dist_q  <= '0;
         diam_q  <= '0;
         tcx_q   <= '0;
         form_q  <= 1'b0;
         bv_q    <= 1'b0;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         start_q <= start_d;
         sw_q    <= sw_d;
         lb_q    <= lb_d;
         rb_q    <= rb_d;
         ls_q    <= ls_d;
         rs_q    <= rs_d;
         cs_q    <= cs_d;
         rem_q   <= rem_d;
         dvd_q   <= dvd_d;
         dsr_q   <= dsr_d;
         cnt_q   <= cnt_d;
         qdist_q <= qdist_d;
         valid_q <= valid_d;
         dist_q  <= dist_d;
         diam_q  <= diam_d;
         tcx_q   <= tcx_d;
         form_q  <= form_d;
         bv_q    <= bv_d;
         drop_q  <= drop_d;
      end
   end

   assign busy                  = (state_q != S_IDLE);
   assign result_valid          = valid_q;
   assign distance              = dist_q;
   assign diameter              = diam_q;
   assign target_center_x_pixel = tcx_q;
   assign formate               = form_q;
   assign building_valid        = bv_q;
   assign frame_drop_cnt        = drop_q;

endmodule

// File: tb/tb_building_measure_sched.sv
// Directed bench for building_measure_sched: table of frames with hand-computed
// results, plus overrun and mid-frame reset sequences.
module tb_building_measure_sched;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        eop = 1'b0;
   logic [10:0] stripe_width = '0, left_most_bound = '0, right_most_bound = '0;
   logic [4:0]  left_slot = '0, right_slot = '0, center_slot = '0;
   logic        busy, result_valid, formate, building_valid;
   logic [11:0] distance, diameter;
   logic [10:0] target_center_x_pixel;
   logic [7:0]  frame_drop_cnt;

   building_measure_sched dut (
      .clk(clk), .reset_n(reset_n), .eop(eop),
      .stripe_width(stripe_width), .left_most_bound(left_most_bound),
      .right_most_bound(right_most_bound), .left_slot(left_slot),
      .right_slot(right_slot), .center_slot(center_slot),
      .busy(busy), .result_valid(result_valid), .distance(distance),
      .diameter(diameter), .target_center_x_pixel(target_center_x_pixel),
      .formate(formate), .building_valid(building_valid),
      .frame_drop_cnt(frame_drop_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [10:0] sw, lb, rb;
      logic [4:0]  ls, rs, cs;
      int          e_dist, e_diam, e_tcx, e_form, e_bv, e_lat;
   } vec_t;

   vec_t vecs[6];
   int   n_vec = 0;
   int   n_fail = 0;
   int   exp_drop = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      stripe_width = v.sw;  left_most_bound = v.lb; right_most_bound = v.rb;
      left_slot = v.ls;     right_slot = v.rs;      center_slot = v.cs;
   endtask

   // drop_k: a second eop lands on edge drop_k with other inputs; abort_k: reset after that edge.
   task automatic run_frame(input vec_t v, input vec_t alt, input int drop_k, input int abort_k);
      int lat = -1;
      int pulses = 0;
      @(negedge clk);
      drive(v);
      eop = 1'b1;
      @(posedge clk);
      @(negedge clk);
      eop = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         #1;
         if (k == 1) chk("busy_after_e1", busy, 1);
         if (k == drop_k) eop = 1'b0;
         if (k == abort_k) begin
            reset_n = 1'b0;
            #1;
            chk("abort_busy", busy, 0);
            chk("abort_distance", distance, 0);
            chk("abort_diameter", diameter, 0);
            chk("abort_tcx", target_center_x_pixel, 0);
            chk("abort_drop", frame_drop_cnt, 0);
         end
         if (result_valid) begin
            pulses++;
            if (lat < 0) begin
               lat = k;
               chk("busy_at_publish", busy, 0);
            end
         end
         if (k == drop_k - 1) begin
            @(negedge clk);
            drive(alt);
            eop = 1'b1;
         end
      end
      if (abort_k > 0) begin
         chk("abort_no_valid", pulses, 0);
      end else begin
         chk("latency", lat, v.e_lat);
         chk("pulse_count", pulses, 1);
         chk("distance", distance, v.e_dist);
         chk("diameter", diameter, v.e_diam);
         chk("target_center_x", target_center_x_pixel, v.e_tcx);
         chk("formate", formate, v.e_form);
         chk("building_valid", building_valid, v.e_bv);
         chk("frame_drop_cnt", frame_drop_cnt, exp_drop);
      end
   endtask

   initial begin
      //          sw       lb       rb       ls     rs     cs    dist  diam  tcx  f  bv lat
      vecs[0] = '{11'd35,  11'd100, 11'd450, 5'd5,  5'd11, 5'd8,  30,   20,   300, 1, 1, 33};
      vecs[1] = '{11'd0,   11'd100, 11'd450, 5'd5,  5'd11, 5'd8,  0,    0,    300, 1, 0, 2};
      vecs[2] = '{11'd7,   11'd500, 11'd200, 5'd1,  5'd15, 5'd3,  150,  0,    100, 0, 0, 33};
      vecs[3] = '{11'd1,   11'd0,   11'd700, 5'd0,  5'd20, 5'd9,  1050, 1278, 340, 1, 0, 33};
      vecs[4] = '{11'd100, 11'd10,  11'd210, 5'd3,  5'd5,  5'd0,  10,   4,    0,   0, 0, 33};
      vecs[5] = '{11'd3,   11'd650, 11'd660, 5'd0,  5'd3,  5'd1,  350,  0,    20,  0, 1, 33};

      for (int c = 0; c < 4; c++) begin
         @(negedge clk); eop = ~eop; stripe_width = 11'd35;
      end
      @(negedge clk);
      eop = 1'b0;
      chk("reset_busy", busy, 0);
      chk("reset_valid", result_valid, 0);
      chk("reset_distance", distance, 0);
      chk("reset_diameter", diameter, 0);
      chk("reset_tcx", target_center_x_pixel, 0);
      chk("reset_formate", formate, 0);
      chk("reset_bv", building_valid, 0);
      chk("reset_drop", frame_drop_cnt, 0);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 6; i++) run_frame(vecs[i], vecs[i], 0, 0);

      exp_drop = 1;
      run_frame(vecs[0], vecs[2], 10, 0);
      run_frame(vecs[2], vecs[2], 0, 0);

      run_frame(vecs[0], vecs[0], 0, 20);
      @(negedge clk);
      reset_n = 1'b1;
      exp_drop = 0;
      repeat (2) @(negedge clk);
      run_frame(vecs[0], vecs[0], 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
